// File: rtl/lift_pkg.sv
// Shared types for the scanning lift controller: car state, travel direction, floor index width.
package lift_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StMoveUp,
      StMoveDown,
      StDoorOpen
   } state_e;

   typedef enum logic {
      DirUp,
      DirDown
   } dir_e;

   function automatic int unsigned floor_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lift_tick_gen.sv
// Tick prescaler: one-clk tick every TICK_DIV cycles, restartable with a synchronous clear.
module lift_tick_gen #(
   parameter int unsigned TICK_DIV = 16777216
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/lift_ctrl_scan.sv
// N-floor lift controller with SCAN request service and tick-timed travel and door dwell.
// Define LIFT_DOOR_OBSTRUCT_EN to add the door_obst input that holds the door open.
module lift_ctrl_scan
   import lift_pkg::*;
#(
   parameter int unsigned N_FLOORS   = 4,
   parameter int unsigned TICK_DIV   = 16777216,
   parameter int unsigned MOVE_TICKS = 2,
   parameter int unsigned DOOR_TICKS = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_FLOORS-1:0]          req_floor,
`ifdef LIFT_DOOR_OBSTRUCT_EN
   input  logic                         door_obst,
`endif
   output logic [N_FLOORS-1:0]          floor_onehot,
   output logic [floor_w(N_FLOORS)-1:0] floor_idx,
   output logic [N_FLOORS-1:0]          pending,
   output logic                         door,
   output logic                         stop,
   output logic                         Up,
   output logic                         Down
);

   localparam int unsigned FW   = floor_w(N_FLOORS);
   localparam int unsigned TMAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   typedef logic [N_FLOORS-1:0] fmask_t;

   state_e         state_q, state_d, sweep_state;
   dir_e           dir_q, dir_d, sweep_dir;
   logic [FW-1:0]  floor_q, floor_d, floor_up, floor_dn;
   fmask_t         pending_q, pending_d, merged, clear_mask, above, below;
   logic [TW-1:0]  tcnt_q, tcnt_d;
   logic           tick, clr, obst, restart, move_done, dwell_done;

`ifdef LIFT_DOOR_OBSTRUCT_EN
   assign obst = door_obst;
`else
   assign obst = 1'b0;
`endif

   assign floor_idx = floor_q;
   assign pending   = pending_q;

   assign merged   = pending_q | req_floor;
   assign above    = pending_q & ~((fmask_t'(2) << floor_q) - fmask_t'(1));
   assign below    = pending_q & ((fmask_t'(1) << floor_q) - fmask_t'(1));
   assign floor_up = floor_q + FW'(1);
   assign floor_dn = floor_q - FW'(1);

   assign move_done  = tick && (tcnt_q == TW'(MOVE_TICKS - 1));
   assign dwell_done = tick && (tcnt_q == TW'(DOOR_TICKS - 1));
   // A call for the floor being served, or an obstruction, re-opens the dwell from zero.
   assign restart    = (state_q == StDoorOpen) && (req_floor[floor_q] || obst);

   // Sweep choice: keep going while work lies ahead, otherwise turn around.
   always_comb begin
      sweep_state = StIdle;
      sweep_dir   = dir_q;
      if (dir_q == DirUp) begin
         if (|above) begin
            sweep_state = StMoveUp;
         end else if (|below) begin
            sweep_state = StMoveDown;
            sweep_dir   = DirDown;
         end
      end else begin
         if (|below) begin
            sweep_state = StMoveDown;
         end else if (|above) begin
            sweep_state = StMoveUp;
            sweep_dir   = DirUp;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      floor_d = floor_q;
      unique case (state_q)
         StIdle: begin
            if (pending_q[floor_q]) begin
               state_d = StDoorOpen;
            end else begin
               state_d = sweep_state;
               dir_d   = sweep_dir;
            end
         end
         StMoveUp: begin
            if (move_done) begin
               if (!(|above)) begin
                  state_d = StIdle;
               end else begin
                  floor_d = floor_up;
                  if (merged[floor_up]) state_d = StDoorOpen;
               end
            end
         end
         StMoveDown: begin
            if (move_done) begin
               if (!(|below)) begin
                  state_d = StIdle;
               end else begin
                  floor_d = floor_dn;
                  if (merged[floor_dn]) state_d = StDoorOpen;
               end
            end
         end
         StDoorOpen: begin
            if (!restart && dwell_done) begin
               state_d = sweep_state;
               dir_d   = sweep_dir;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign clr = (state_d != state_q) || (floor_d != floor_q) || restart;

   always_comb begin
      tcnt_d = tcnt_q;
      if (clr) begin
         tcnt_d = '0;
      end else if (tick && (state_q != StIdle)) begin
         tcnt_d = tcnt_q + TW'(1);
      end
   end

   // The served floor is dropped on door entry and kept clear for the whole dwell.
   assign clear_mask = ((state_d == StDoorOpen) || (state_q == StDoorOpen)) ?
                       (fmask_t'(1) << floor_d) : '0;
   assign pending_d  = merged & ~clear_mask;

   lift_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .reset(reset),
      .clear(clr),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         dir_q        <= DirUp;
         floor_q      <= '0;
         pending_q    <= '0;
         tcnt_q       <= '0;
         floor_onehot <= fmask_t'(1);
         door         <= 1'b1;
         stop         <= 1'b1;
         Up           <= 1'b0;
         Down         <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         floor_q      <= floor_d;
         pending_q    <= pending_d;
         tcnt_q       <= tcnt_d;
         floor_onehot <= fmask_t'(1) << floor_d;
         door         <= (state_d == StIdle) || (state_d == StDoorOpen);
         stop         <= (state_d == StIdle) || (state_d == StDoorOpen);
         Up           <= (state_d == StMoveUp);
         Down         <= (state_d == StMoveDown);
      end
   end

endmodule

// File: tb/tb_lift_ctrl_scan.sv
// Bench for lift_ctrl_scan: vector table, corner sequences and random traffic against a timer model.
module tb_lift_ctrl_scan;

   localparam int NF        = 4;
   localparam int TDIV      = 4;
   localparam int MT        = 2;
   localparam int DT        = 3;
   localparam int MOVE_CLK  = MT * TDIV;
   localparam int DOOR_CLK  = DT * TDIV;
   localparam int NV        = 17;
   localparam int MIdle     = 0;
   localparam int MMove     = 1;
   localparam int MDoor     = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [NF-1:0] req_floor = '0;
`ifdef LIFT_DOOR_OBSTRUCT_EN
   logic          door_obst = 1'b0;
`endif
   logic [NF-1:0] floor_onehot, pending;
   logic [1:0]    floor_idx;
   logic          door, stop, Up, Down;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lift_ctrl_scan #(
      .N_FLOORS  (NF),
      .TICK_DIV  (TDIV),
      .MOVE_TICKS(MT),
      .DOOR_TICKS(DT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_floor   (req_floor),
`ifdef LIFT_DOOR_OBSTRUCT_EN
      .door_obst   (door_obst),
`endif
      .floor_onehot(floor_onehot),
      .floor_idx   (floor_idx),
      .pending     (pending),
      .door        (door),
      .stop        (stop),
      .Up          (Up),
      .Down        (Down)
   );

   // Reference model: floor number, +1/-1 direction, and a clock countdown per activity.
   int            m_floor = 0;
   int            m_dir   = 1;
   int            m_mode  = MIdle;
   int            m_timer = 0;
   int            m_pick  = 0;
   logic [NF-1:0] m_pend  = '0;
   logic [NF-1:0] m_merged;
   logic          m_was_door, m_obst;

   function automatic int count_dir(logic [NF-1:0] p, int f, int d);
      int c = 0;
      for (int i = 0; i < NF; i++)
         if (p[i] && ((d > 0 && i > f) || (d < 0 && i < f))) c++;
      return c;
   endfunction

   function automatic int pick_dir(logic [NF-1:0] p, int f, int d);
      if (count_dir(p, f, d) > 0) return d;
      if (count_dir(p, f, -d) > 0) return -d;
      return 0;
   endfunction

   task model_step();
      if (!reset) begin
         m_floor = 0; m_dir = 1; m_mode = MIdle; m_timer = 0; m_pend = '0;
      end else begin
         m_merged   = m_pend | req_floor;
         m_was_door = (m_mode == MDoor);
`ifdef LIFT_DOOR_OBSTRUCT_EN
         m_obst = door_obst;
`else
         m_obst = 1'b0;
`endif
         case (m_mode)
            MIdle: begin
               if (m_pend[m_floor]) begin
                  m_mode = MDoor; m_timer = DOOR_CLK;
               end else begin
                  m_pick = pick_dir(m_pend, m_floor, m_dir);
                  if (m_pick != 0) begin
                     m_dir = m_pick; m_mode = MMove; m_timer = MOVE_CLK;
                  end
               end
            end
            MMove: begin
               m_timer--;
               if (m_timer == 0) begin
                  m_floor += m_dir;
                  if (m_merged[m_floor]) begin
                     m_mode = MDoor; m_timer = DOOR_CLK;
                  end else if (count_dir(m_pend, m_floor, m_dir) > 0) begin
                     m_timer = MOVE_CLK;
                  end else begin
                     m_mode = MIdle;
                  end
               end
            end
            default: begin
               if (req_floor[m_floor] || m_obst) begin
                  m_timer = DOOR_CLK;
               end else begin
                  m_timer--;
                  if (m_timer == 0) begin
                     m_pick = pick_dir(m_pend, m_floor, m_dir);
                     if (m_pick != 0) begin
                        m_dir = m_pick; m_mode = MMove; m_timer = MOVE_CLK;
                     end else begin
                        m_mode = MIdle;
                     end
                  end
               end
            end
         endcase
         m_pend = m_merged;
         if (m_was_door || m_mode == MDoor) m_pend[m_floor] = 1'b0;
      end
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic check_model();
      logic [NF-1:0] oh;
      logic          still;
      oh = '0;
      oh[m_floor] = 1'b1;
      still = (m_mode != MMove);
      check("lockstep", {floor_idx, floor_onehot, pending, door, stop, Up, Down},
            {m_floor[1:0], oh, m_pend, still, still,
             (m_mode == MMove && m_dir > 0), (m_mode == MMove && m_dir < 0)});
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   typedef struct {
      logic [NF-1:0] req;
      int            wait_cyc;
      int            fl;
      logic          dr;
      logic          up;
      logic          dn;
      logic [NF-1:0] pend;
   } vec_t;

   vec_t vecs[NV];

   initial begin
      int n;
      bit saw;

      vecs[0]  = '{4'b0000, 5,  0, 1'b1, 1'b0, 1'b0, 4'b0000};
      vecs[1]  = '{4'b1000, 1,  0, 1'b1, 1'b0, 1'b0, 4'b1000};
      vecs[2]  = '{4'b0000, 1,  0, 1'b0, 1'b1, 1'b0, 4'b1000};
      vecs[3]  = '{4'b0000, 8,  1, 1'b0, 1'b1, 1'b0, 4'b1000};
      vecs[4]  = '{4'b0000, 16, 3, 1'b1, 1'b0, 1'b0, 4'b0000};
      vecs[5]  = '{4'b0000, 11, 3, 1'b1, 1'b0, 1'b0, 4'b0000};
      vecs[6]  = '{4'b0001, 1,  3, 1'b1, 1'b0, 1'b0, 4'b0001};
      vecs[7]  = '{4'b0000, 1,  3, 1'b0, 1'b0, 1'b1, 4'b0001};
      vecs[8]  = '{4'b0000, 8,  2, 1'b0, 1'b0, 1'b1, 4'b0001};
      vecs[9]  = '{4'b0000, 16, 0, 1'b1, 1'b0, 1'b0, 4'b0000};
      vecs[10] = '{4'b0000, 12, 0, 1'b1, 1'b0, 1'b0, 4'b0000};
      vecs[11] = '{4'b1010, 1,  0, 1'b1, 1'b0, 1'b0, 4'b1010};
      vecs[12] = '{4'b0000, 1,  0, 1'b0, 1'b1, 1'b0, 4'b1010};
      vecs[13] = '{4'b0000, 8,  1, 1'b1, 1'b0, 1'b0, 4'b1000};
      vecs[14] = '{4'b0000, 11, 1, 1'b1, 1'b0, 1'b0, 4'b1000};
      vecs[15] = '{4'b0000, 1,  1, 1'b0, 1'b1, 1'b0, 4'b1000};
      vecs[16] = '{4'b0000, 16, 3, 1'b1, 1'b0, 1'b0, 4'b0000};

      reset = 1'b0;
      repeat (3) cyc();
      check("reset_state", {floor_idx, floor_onehot, pending, door, stop, Up, Down},
            {2'd0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
      reset = 1'b1;

      for (int k = 0; k < NV; k++) begin
         req_floor = vecs[k].req;
         for (int w = 0; w < vecs[k].wait_cyc; w++) begin
            cyc();
            req_floor = '0;
         end
         check($sformatf("vec%0d", k), {floor_idx, door, Up, Down, pending},
               {2'(vecs[k].fl), vecs[k].dr, vecs[k].up, vecs[k].dn, vecs[k].pend});
      end

      // Down sweep with a call behind the car: serve 0, then reverse to 3.
      repeat (12) cyc();
      req_floor = 4'b0001; cyc(); req_floor = '0;
      n = 0;
      while (floor_idx != 2'd2 && n < 40) begin cyc(); n++; end
      check("down_at_2", {floor_idx, Down}, {2'd2, 1'b1});
      req_floor = 4'b1001; cyc(); req_floor = '0;
      check("hold_passed_req", pending, 4'b1001);
      n = 0; saw = 0;
      while (!(door && floor_idx == 2'd0) && n < 40) begin
         cyc(); n++;
         if (Up) saw = 1;
      end
      check("serve_0", {floor_idx, door, pending}, {2'd0, 1'b1, 4'b1000});
      check("no_up_on_down_sweep", 32'(saw), 0);
      n = 0;
      while (!Up && n < 30) begin cyc(); n++; end
      check("reverse_after_dwell", n, 12);
      n = 0;
      while (!(door && floor_idx == 2'd3) && n < 40) begin cyc(); n++; end
      check("serve_3", {floor_idx, door, pending}, {2'd3, 1'b1, 4'b0000});

      // Reset while moving down at floor 2.
      repeat (12) cyc();
      req_floor = 4'b0001; cyc(); req_floor = '0;
      n = 0;
      while (floor_idx != 2'd2 && n < 40) begin cyc(); n++; end
      check("pend_before_reset", {floor_idx, pending, Down}, {2'd2, 4'b0001, 1'b1});
      reset = 1'b0; cyc();
      check("reset_mid_move", {floor_idx, floor_onehot, pending, door, stop, Up, Down},
            {2'd0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
      reset = 1'b1; cyc();

      // Call for the current floor during dwell restarts the dwell.
      req_floor = 4'b0001; cyc(); req_floor = '0; cyc();
      check("door_at_0", {door, pending}, {1'b1, 4'b0000});
      repeat (5) cyc();
      req_floor = 4'b0001; cyc();
      check("cur_req_not_latched", pending, 4'b0000);
      req_floor = 4'b0100; cyc(); req_floor = '0;
      n = 1;
      while (!Up && n < 30) begin cyc(); n++; end
      check("door_restart", n, 12);

`ifdef LIFT_DOOR_OBSTRUCT_EN
      n = 0;
      while (!(door && floor_idx == 2'd2) && n < 40) begin cyc(); n++; end
      check("obst_door_at_2", {floor_idx, door}, {2'd2, 1'b1});
      door_obst = 1'b1;
      req_floor = 4'b1000; cyc(); req_floor = '0;
      saw = 0;
      repeat (39) begin
         cyc();
         if (!door) saw = 1;
      end
      check("obst_holds_door", {32'(saw), pending}, {32'd0, 4'b1000});
      door_obst = 1'b0;
      n = 0;
      while (!Up && n < 40) begin cyc(); n++; end
      check("obst_release", n, 12);
`endif

      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         req_floor = ($urandom_range(0, 7) == 0) ? NF'($urandom_range(0, 15)) : '0;
         cyc();
      end
      reset = 1'b1;
      req_floor = '0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
